// File: rtl/dclab_pkg.sv
// Shared types and default timing constants for the dclab control blocks.
package dclab_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } key_state_t;

    localparam int unsigned CLK_HZ         = 32'd50_000_000;
    // 5 ms debounce, 0.5 s initial hold, 0.1 s repeat period at CLK_HZ
    localparam int unsigned DEB_DEFAULT    = CLK_HZ / 32'd200;
    localparam int unsigned HOLD_DEFAULT   = CLK_HZ / 32'd2;
    localparam int unsigned REPEAT_DEFAULT = CLK_HZ / 32'd10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Synchroniser chain; reset value is chosen by the user of the input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button and emits press, release and
// hold-to-repeat single-cycle pulses.
module key_debounce
    import dclab_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_DEFAULT,
    parameter int unsigned HOLD_CYCLES   = HOLD_DEFAULT,
    parameter int unsigned REPEAT_CYCLES = REPEAT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    logic              key_sync_s;
    logic              ksync_d, ksync_q;
    logic [DEB_W-1:0]  deb_cnt_d, deb_cnt_q;
    logic              level_d, level_q;
    logic              accept_s;
    logic              acc_press_s, acc_release_s;
    key_state_t        state_d, state_q;
    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d, rep_cnt_q;
    logic              press_d, press_q;
    logic              release_d, release_q;
    logic              repeat_d, repeat_q;

    // Idle key reads as released (1) so reset never fakes a press.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_key_n),
        .o_q     (key_sync_s)
    );

    // Stability counter: a level change is accepted after DEB_CYCLES
    // consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
        ksync_d   = ~key_sync_s;
        deb_cnt_d = {DEB_W{1'b0}};
        level_d   = level_q;
        accept_s  = 1'b0;
        if (ksync_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d  = ~level_q;
                accept_s = 1'b1;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
        end else begin
            deb_cnt_d = {DEB_W{1'b0}};
        end
    end

    assign acc_press_s   = accept_s & ~level_q;
    assign acc_release_s = accept_s &  level_q;

    // Hold/repeat FSM; a release on an expiry cycle takes priority.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_press_s) begin
                    state_d    = S_HOLD;
                    press_d    = 1'b1;
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (acc_release_s) begin
                    state_d    = S_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = {HOLD_W{1'b0}};
                    rep_cnt_d  = {REP_W{1'b0}};
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_REPEAT;
                    repeat_d   = 1'b1;
                    hold_cnt_d = {HOLD_W{1'b0}};
                    rep_cnt_d  = {REP_W{1'b0}};
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            S_REPEAT: begin
                if (acc_release_s) begin
                    state_d    = S_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = {HOLD_W{1'b0}};
                    rep_cnt_d  = {REP_W{1'b0}};
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = {REP_W{1'b0}};
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_ONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                hold_cnt_d = {HOLD_W{1'b0}};
                rep_cnt_d  = {REP_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ksync_q    <= 1'b0;
            deb_cnt_q  <= {DEB_W{1'b0}};
            level_q    <= 1'b0;
            state_q    <= S_IDLE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            rep_cnt_q  <= {REP_W{1'b0}};
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            ksync_q    <= ksync_d;
            deb_cnt_q  <= deb_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a sample-window model.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_key_n;
    logic o_level, o_press, o_release, o_repeat;

    int checks   = 0;
    int failures = 0;

    // model state: raw samples per edge, accepted level, edges since press
    bit       hist[$];
    bit       m_level;
    int       m_age;
    logic [3:0] exp_vec;
    logic [3:0] obs;

    key_debounce #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_key_n   (i_key_n),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    always #5 i_clk = ~i_clk;

    assign obs = {o_level, o_press, o_release, o_repeat};

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < DEB + 3; k++) hist.push_back(1'b0);
        m_level = 1'b0;
        m_age   = 0;
        exp_vec = 4'b0000;
    endfunction

    // A change is accepted when the DEB samples taken 3..DEB+2 edges ago all
    // disagree with the level. Repeats fall at HOLD + k*REP edges after press.
    function automatic void model_edge(input bit pressed);
        int  last;
        bit  flip, p, r, rp;
        hist.push_back(pressed);
        if (hist.size() > 64) void'(hist.pop_front());
        last = hist.size() - 1;
        flip = 1'b1;
        for (int k = 0; k < DEB; k++)
            if (hist[last - 3 - k] == m_level) flip = 1'b0;
        p  = flip && !m_level;
        r  = flip && m_level;
        rp = 1'b0;
        if (m_level) begin
            m_age++;
            if (!flip && m_age >= HOLD && ((m_age - HOLD) % REP) == 0) rp = 1'b1;
        end
        if (flip) begin
            m_level = !m_level;
            m_age   = 0;
        end
        exp_vec = {m_level, p, r, rp};
    endfunction

    task automatic drive_cycle(input logic key_n);
        i_key_n = key_n;
        @(posedge i_clk);
        model_edge(!key_n);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_key_n = 1'b1;
        #12;
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000", obs);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL reset_idle i=%0d got=%b want=%b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        int press_at = -1, presses = 0, rel_at = -1;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(1'b0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL clean_press i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_press) begin presses++; if (press_at < 0) press_at = i; end
        end
        checks++;
        if (press_at != 6 || presses != 1) begin
            failures++;
            $display("FAIL clean_press_edge got=%0d/%0d want=6/1", press_at, presses);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL clean_release i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_release && rel_at < 0) rel_at = i;
        end
        checks++;
        if (rel_at != 6) begin
            failures++;
            $display("FAIL clean_release_edge got=%0d want=6", rel_at);
        end
    endtask

    task automatic test_bounce();
        int press_at = -1, presses = 0;
        logic k;
        for (int i = 0; i < 30; i++) begin
            k = (i < 8) ? logic'((i / 2) % 2) : 1'b0;
            drive_cycle(k);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL bounce i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_press) begin presses++; if (press_at < 0) press_at = i; end
        end
        checks++;
        if (press_at != 14 || presses != 1) begin
            failures++;
            $display("FAIL bounce_single got=%0d/%0d want=14/1", press_at, presses);
        end
        for (int i = 0; i < 15; i++) drive_cycle(1'b1);
    endtask

    task automatic test_glitch();
        int events = 0;
        for (int i = 0; i < 23; i++) begin
            drive_cycle((i < 3) ? 1'b0 : 1'b1);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL glitch i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_press || o_level) events++;
        end
        checks++;
        if (events != 0) begin
            failures++;
            $display("FAIL glitch_ignored got=%0d want=0", events);
        end
    endtask

    task automatic test_hold();
        int first_rep = -1, reps = 0, rel_at = -1;
        for (int i = 0; i < 60; i++) begin
            drive_cycle(1'b0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL hold i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_press && o_repeat) begin
                failures++;
                $display("FAIL hold_overlap i=%0d got=11 want=not both", i);
            end
            if (o_repeat) begin reps++; if (first_rep < 0) first_rep = i; end
        end
        checks++;
        if (first_rep != 26 || reps != 7) begin
            failures++;
            $display("FAIL hold_repeats got=%0d/%0d want=26/7", first_rep, reps);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL hold_release i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_release && rel_at < 0) rel_at = i;
        end
        checks++;
        if (rel_at != 6) begin
            failures++;
            $display("FAIL hold_release_edge got=%0d want=6", rel_at);
        end
    endtask

    task automatic test_release_at_expiry();
        int rel_at = -1, reps = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle((i < 20) ? 1'b0 : 1'b1);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL expiry i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_release && rel_at < 0) rel_at = i;
            if (o_repeat) reps++;
        end
        checks++;
        if (rel_at != 26 || reps != 0) begin
            failures++;
            $display("FAIL expiry_release_wins got=%0d/%0d want=26/0", rel_at, reps);
        end
    endtask

    task automatic test_reset_mid_hold();
        int press_at = -1, presses = 0;
        for (int i = 0; i < 40; i++) drive_cycle(1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL midhold_async_reset got=%b want=0000", obs);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            drive_cycle(1'b0);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL midhold_after i=%0d got=%b want=%b", i, obs, exp_vec);
            end
            if (o_release) begin
                failures++;
                $display("FAIL midhold_no_release i=%0d got=1 want=0", i);
            end
            if (o_press) begin presses++; if (press_at < 0) press_at = i; end
        end
        checks++;
        if (press_at != 6 || presses != 1) begin
            failures++;
            $display("FAIL midhold_press got=%0d/%0d want=6/1", press_at, presses);
        end
        for (int i = 0; i < 20; i++) drive_cycle(1'b1);
    endtask

    task automatic test_random();
        logic k = 1'b1;
        int   run;
        int   cyc = 0;
        while (cyc < 600) begin
            k   = ~k;
            run = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 7);
            for (int j = 0; j < run; j++) begin
                drive_cycle(k);
                cyc++;
                checks++;
                if (obs !== exp_vec) begin
                    failures++;
                    $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_hold();
        test_release_at_expiry();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
